// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pc_pkg
//  Description : Shared constants for the program-counter sequencer: default
//                geometry, the next-PC source select encoding and a log2
//                helper used for the alignment mask and RAS pointer width.
//  Revision    : 1.0 - initial release
// ============================================================================
package pc_pkg;

    localparam int          c_default_width        = 32;
    localparam int          c_default_step         = 4;
    localparam logic [31:0] c_default_reset_vector = 32'h0000_0000;
    localparam int          c_default_ras_depth    = 4;

    // Next-PC source select, listed in priority order (highest first).
    localparam int                 c_sel_w       = 3;
    localparam logic [c_sel_w-1:0] SEL_RET       = 3'd0;
    localparam logic [c_sel_w-1:0] SEL_RET_EMPTY = 3'd1;
    localparam logic [c_sel_w-1:0] SEL_BRANCH    = 3'd2;
    localparam logic [c_sel_w-1:0] SEL_JUMP      = 3'd3;
    localparam logic [c_sel_w-1:0] SEL_HOLD      = 3'd4;
    localparam logic [c_sel_w-1:0] SEL_SEQ       = 3'd5;

    // Ceiling log2; exact for the power-of-two values used here.
    function automatic int log2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pc_sequencer_ras_stack.sv
`default_nettype none
// ============================================================================
//  Module      : ras_stack
//  Description : Circular return-address stack. A push while full overwrites
//                the oldest entry; push+pop in one cycle replaces the top.
//  Ports       : clk, rst_n (async, active low)
//                push, pop, push_data[WIDTH]  -> operation request
//                top_data[WIDTH]              <- current top entry
//                empty, full                  <- occupancy
//                overflow                     <- sticky: push while full
//  Revision    : 1.0 - initial release
// ============================================================================
module ras_stack
    import pc_pkg::*;
#(
    parameter int WIDTH     = c_default_width,
    parameter int RAS_DEPTH = c_default_ras_depth
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top_data,
    output logic             empty,
    output logic             full,
    output logic             overflow
);

    localparam int c_ptr_w = log2(RAS_DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(RAS_DEPTH);

    logic [WIDTH-1:0]   r_mem [RAS_DEPTH];
    logic [c_ptr_w-1:0] r_top;
    logic [c_cnt_w-1:0] r_count;
    logic               r_overflow;

    logic               w_do_pop;
    logic               w_replace;
    logic [c_ptr_w-1:0] w_wr_ptr;

    assign empty    = (r_count == '0);
    assign full     = (r_count == c_depth);
    assign overflow = r_overflow;
    assign top_data = r_mem[r_top];

    // A pop on an empty stack is a no-op; push+pop on a non-empty stack
    // rewrites the top slot in place and leaves pointer and count alone.
    assign w_do_pop  = pop && !empty;
    assign w_replace = push && w_do_pop;
    assign w_wr_ptr  = w_replace ? r_top : r_top + c_ptr_w'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_top      <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (w_replace) begin
            r_top      <= r_top;
        end else if (push) begin
            // Pointer wraps naturally; when full the slot ahead is the oldest.
            r_top <= r_top + c_ptr_w'(1);
            if (full) begin
                r_overflow <= 1'b1;
            end else begin
                r_count <= r_count + c_cnt_w'(1);
            end
        end else if (w_do_pop) begin
            r_top   <= r_top - c_ptr_w'(1);
            r_count <= r_count - c_cnt_w'(1);
        end
    end

    // Storage carries no reset: occupancy is tracked by r_count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[w_wr_ptr] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pc_sequencer
//  Description : Registered program counter with configurable step, redirect
//                priority (return > branch > jump), stall hold and an
//                internal circular return-address stack.
//  Ports       : Clk, Reset (async, active low)
//                Stall, BranchTaken/BranchTarget, Jump/JumpTarget, Call, Ret
//                PC (registered), PCAddResult (PC+STEP, combinational)
//                RasEmpty, RasFull, RasOverflow, RasUnderflow, AlignFault
//  Options     : PC_ALIGN_CHECK_EN - when defined, misaligned redirect and
//                return targets are forced to STEP alignment and AlignFault
//                is set (sticky). When undefined AlignFault is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int               WIDTH        = c_default_width,
    parameter int               STEP         = c_default_step,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(c_default_reset_vector),
    parameter int               RAS_DEPTH    = c_default_ras_depth
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Stall,
    input  logic             BranchTaken,
    input  logic [WIDTH-1:0] BranchTarget,
    input  logic             Jump,
    input  logic [WIDTH-1:0] JumpTarget,
    input  logic             Call,
    input  logic             Ret,
    output logic [WIDTH-1:0] PC,
    output logic [WIDTH-1:0] PCAddResult,
    output logic             RasEmpty,
    output logic             RasFull,
    output logic             RasOverflow,
    output logic             RasUnderflow,
    output logic             AlignFault
);

    logic [WIDTH-1:0]   r_pc;
    logic               r_underflow;

    logic [c_sel_w-1:0] w_sel;
    logic [WIDTH-1:0]   w_target;
    logic [WIDTH-1:0]   w_next_pc;
    logic [WIDTH-1:0]   w_pc_add;
    logic [WIDTH-1:0]   w_ras_top;
    logic               w_push;
    logic               w_pop;
    logic               w_underflow_set;

    assign w_pc_add     = r_pc + WIDTH'(STEP);
    assign PC           = r_pc;
    assign PCAddResult  = w_pc_add;
    assign RasUnderflow = r_underflow;

    ras_stack #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (Clk),
        .rst_n     (Reset),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (w_pc_add),
        .top_data  (w_ras_top),
        .empty     (RasEmpty),
        .full      (RasFull),
        .overflow  (RasOverflow)
    );

    // State register: PC and sticky underflow.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_pc        <= RESET_VECTOR;
            r_underflow <= 1'b0;
        end else begin
            r_pc <= w_next_pc;
            if (w_underflow_set) begin
                r_underflow <= 1'b1;
            end
        end
    end

    // Source select. Redirects win over Stall because they flush fetch.
    always_comb begin
        w_sel = SEL_SEQ;
        if (Ret && !RasEmpty) begin
            w_sel = SEL_RET;
        end else if (Ret) begin
            w_sel = SEL_RET_EMPTY;
        end else if (BranchTaken) begin
            w_sel = SEL_BRANCH;
        end else if (Jump) begin
            w_sel = SEL_JUMP;
        end else if (Stall) begin
            w_sel = SEL_HOLD;
        end
    end

    // Target and RAS controls. Call only counts when Jump is the chosen
    // source, or alongside a successful Ret, where it becomes a top replace.
    always_comb begin
        w_target        = w_pc_add;
        w_push          = 1'b0;
        w_pop           = 1'b0;
        w_underflow_set = 1'b0;
        case (w_sel)
            SEL_RET: begin
                w_target = w_ras_top;
                w_pop    = 1'b1;
                w_push   = Call && Jump;
            end
            SEL_RET_EMPTY: begin
                w_underflow_set = 1'b1;
            end
            SEL_BRANCH: begin
                w_target = BranchTarget;
            end
            SEL_JUMP: begin
                w_target = JumpTarget;
                w_push   = Call;
            end
            SEL_HOLD: begin
                w_target = r_pc;
            end
            default: begin
                w_target = w_pc_add;
            end
        endcase
    end

`ifdef PC_ALIGN_CHECK_EN
    localparam int               c_align_bits = log2(STEP);
    localparam logic [WIDTH-1:0] c_align_mask = WIDTH'((1 << c_align_bits) - 1);

    logic r_align_fault;
    logic w_redirect;
    logic w_misaligned;

    assign w_redirect   = (w_sel == SEL_RET) || (w_sel == SEL_BRANCH) || (w_sel == SEL_JUMP);
    assign w_misaligned = w_redirect && ((w_target & c_align_mask) != '0);
    assign w_next_pc    = w_redirect ? (w_target & ~c_align_mask) : w_target;
    assign AlignFault   = r_align_fault;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_align_fault <= 1'b0;
        end else if (w_misaligned) begin
            r_align_fault <= 1'b1;
        end
    end
`else
    assign w_next_pc  = w_target;
    assign AlignFault = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_sequencer
//  Description : Self-checking bench for pc_sequencer at default parameters.
//                A queue-based reference model tracks PC and the RAS; every
//                falling edge the DUT outputs are compared to it, and directed
//                steps add hand-computed literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        Stall = 1'b0;
    logic        BranchTaken = 1'b0;
    logic [31:0] BranchTarget = '0;
    logic        Jump = 1'b0;
    logic [31:0] JumpTarget = '0;
    logic        Call = 1'b0;
    logic        Ret = 1'b0;
    logic [31:0] PC;
    logic [31:0] PCAddResult;
    logic        RasEmpty;
    logic        RasFull;
    logic        RasOverflow;
    logic        RasUnderflow;
    logic        AlignFault;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 Clk = ~Clk;

    pc_sequencer #(
        .WIDTH        (32),
        .STEP         (4),
        .RESET_VECTOR (32'h0),
        .RAS_DEPTH    (4)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Stall        (Stall),
        .BranchTaken  (BranchTaken),
        .BranchTarget (BranchTarget),
        .Jump         (Jump),
        .JumpTarget   (JumpTarget),
        .Call         (Call),
        .Ret          (Ret),
        .PC           (PC),
        .PCAddResult  (PCAddResult),
        .RasEmpty     (RasEmpty),
        .RasFull      (RasFull),
        .RasOverflow  (RasOverflow),
        .RasUnderflow (RasUnderflow),
        .AlignFault   (AlignFault)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: PC as a number, RAS as a queue (back = top).
    // ------------------------------------------------------------------
    logic [31:0] m_pc;
    logic [31:0] m_ras[$];
    logic        m_ovf;
    logic        m_unf;
    logic        m_af;
    logic [31:0] m_link;

    function automatic logic [31:0] fix_align(input logic [31:0] t);
`ifdef PC_ALIGN_CHECK_EN
        if (t[1:0] != 2'b00) m_af = 1'b1;
        return {t[31:2], 2'b00};
`else
        return t;
`endif
    endfunction

    always @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            m_pc  = 32'h0;
            m_ras.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
            m_af  = 1'b0;
        end else begin
            m_link = m_pc + 32'd4;
            if (Ret && m_ras.size() > 0) begin
                m_pc = fix_align(m_ras[m_ras.size()-1]);
                if (Call && Jump) m_ras[m_ras.size()-1] = m_link;
                else m_ras.delete(m_ras.size()-1);
            end else if (Ret) begin
                m_pc  = m_link;
                m_unf = 1'b1;
            end else if (BranchTaken) begin
                m_pc = fix_align(BranchTarget);
            end else if (Jump) begin
                if (Call) begin
                    if (m_ras.size() == 4) begin
                        m_ras.delete(0);
                        m_ovf = 1'b1;
                    end
                    m_ras.push_back(m_link);
                end
                m_pc = fix_align(JumpTarget);
            end else if (!Stall) begin
                m_pc = m_link;
            end
        end
    end

    always @(negedge Clk) begin
        check("pc", PC, m_pc);
        check("pc_add", PCAddResult, m_pc + 32'd4);
        check("ras_empty", 32'(RasEmpty), 32'(m_ras.size() == 0));
        check("ras_full", 32'(RasFull), 32'(m_ras.size() == 4));
        check("ras_overflow", 32'(RasOverflow), 32'(m_ovf));
        check("ras_underflow", 32'(RasUnderflow), 32'(m_unf));
        check("align_fault", 32'(AlignFault), 32'(m_af));
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic tick();
        @(negedge Clk);
        #1;
    endtask

    task automatic step(input logic st, input logic br, input logic [31:0] bt,
                        input logic j, input logic [31:0] jt,
                        input logic c, input logic r);
        Stall = st; BranchTaken = br; BranchTarget = bt;
        Jump = j; JumpTarget = jt; Call = c; Ret = r;
        tick();
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rets [4];
        rets[0] = 32'h14; rets[1] = 32'h10; rets[2] = 32'hC; rets[3] = 32'h8;

        // Reset for two cycles.
        tick(); tick();
        check("rst_pc", PC, 32'h0);
        check("rst_empty", 32'(RasEmpty), 32'h1);
        check("rst_full", 32'(RasFull), 32'h0);
        check("rst_ovf", 32'(RasOverflow), 32'h0);
        check("rst_unf", 32'(RasUnderflow), 32'h0);
        check("rst_af", 32'(AlignFault), 32'h0);
        Reset = 1'b1;
        check("seq_pc0", PC, 32'h0);
        idle(); check("seq_pc4", PC, 32'h4); check("seq_add8", PCAddResult, 32'h8);
        idle(); check("seq_pc8", PC, 32'h8);
        idle(); check("seq_pcC", PC, 32'hC);
        idle(); check("seq_pc10", PC, 32'h10);

        // Stall holds; branch overrides stall.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
            check("stall_hold", PC, 32'h10);
        end
        step(1'b1, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0);
        check("stall_branch", PC, 32'h100);

        // Branch beats Jump+Call, no push.
        step(1'b0, 1'b1, 32'h200, 1'b1, 32'h300, 1'b1, 1'b0);
        check("br_over_jmp", PC, 32'h200);
        check("br_no_push", 32'(RasEmpty), 32'h1);

        // Ret beats branch: RAS top 0x44.
        step(1'b0, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 32'h500, 1'b1, 1'b0);
        check("call_pc", PC, 32'h500);
        step(1'b0, 1'b1, 32'h600, 1'b0, 32'h0, 1'b0, 1'b1);
        check("ret_over_br", PC, 32'h44);

        // Call / return / underflow.
        step(1'b0, 1'b1, 32'h20, 1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 32'h80, 1'b1, 1'b0);
        check("call80", PC, 32'h80);
        idle(); idle();
        check("pc88", PC, 32'h88);
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        check("ret24", PC, 32'h24);
        check("ret_empty", 32'(RasEmpty), 32'h1);
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        check("ret_unf_pc", PC, 32'h28);
        check("ret_unf", 32'(RasUnderflow), 32'h1);

        // Five calls into a four-deep stack.
        step(1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1, 32'(i * 4), 1'b1, 1'b0);
        end
        check("ovf_full", 32'(RasFull), 32'h1);
        check("ovf_flag", 32'(RasOverflow), 32'h1);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
            check("ovf_ret", PC, rets[i]);
        end
        check("ovf_drained", 32'(RasEmpty), 32'h1);

        // Ret+Call+Jump replaces the top entry.
        step(1'b0, 1'b1, 32'h1000, 1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 32'h2000, 1'b1, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 32'h3000, 1'b1, 1'b1);
        check("repl_pc", PC, 32'h1004);
        check("repl_nonempty", 32'(RasEmpty), 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        check("repl_ret", PC, 32'h2004);
        check("repl_empty", 32'(RasEmpty), 32'h1);

        // Wrap modulo 2^32.
        step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 1'b0);
        check("wrap_add", PCAddResult, 32'h0);
        idle();
        check("wrap_pc", PC, 32'h0);

        // Misaligned jump target.
        step(1'b0, 1'b0, 32'h0, 1'b1, 32'h103, 1'b0, 1'b0);
`ifdef PC_ALIGN_CHECK_EN
        check("align_pc", PC, 32'h100);
        check("align_fault", 32'(AlignFault), 32'h1);
`else
        check("align_pc", PC, 32'h103);
        check("align_fault", 32'(AlignFault), 32'h0);
`endif

        // Random mix, compared against the model every cycle.
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 5) == 0),
                 $urandom & 32'h0000_0FFC, 1'($urandom_range(0, 2) == 0),
                 $urandom & 32'h0000_0FFC, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 3) == 0));
        end

        // Asynchronous reset mid-run.
        Reset = 1'b0;
        #1;
        check("mid_rst_pc", PC, 32'h0);
        check("mid_rst_af", 32'(AlignFault), 32'h0);
        check("mid_rst_ovf", 32'(RasOverflow), 32'h0);
        check("mid_rst_unf", 32'(RasUnderflow), 32'h0);
        check("mid_rst_empty", 32'(RasEmpty), 32'h1);
        idle(); idle();
        Reset = 1'b1;
        idle();
        check("restart_pc", PC, 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
